ct_idu_rf_vreg_wb_stage: RTL and testbench

- Write-back staging block directly upstream of the per-entry gated vreg registers in the IDU RF vector physical register file.
- Captures the three vreg write-back sources (VFPU ex5 pipe6, VFPU ex5 pipe7, LSU pipe3) in one register stage.
- Decodes each preg index into the 3-bit one-hot write-valid vector each register entry consumes.
- Maintains a per-preg ready scoreboard: set on write-back, cleared on rename allocation.

---
 rtl/ct_idu_rf_vreg_wb_stage.sv | 131 +++++++++++++
 tb/tb_ct_idu_rf_vreg_wb_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_idu_rf_vreg_wb_stage.sv
// Vreg write-back staging: registers pipe6/pipe7/lsu write-backs, decodes them into per-entry one-hot
// write valids and keeps the per-preg ready scoreboard. Collision checking: CT_IDU_VREG_WB_COLLISION_CHK_EN.
module ct_idu_rf_vreg_wb_stage #(
  parameter int PREG_NUM = 64,
  parameter int PREG_W   = 6,
  parameter int DATA_W   = 64
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    vfpu_idu_ex5_pipe6_wb_vreg_vld,
  input  logic [PREG_W-1:0]       vfpu_idu_ex5_pipe6_wb_vreg_preg,
  input  logic [DATA_W-1:0]       vfpu_idu_ex5_pipe6_wb_vreg_data,
  input  logic                    vfpu_idu_ex5_pipe7_wb_vreg_vld,
  input  logic [PREG_W-1:0]       vfpu_idu_ex5_pipe7_wb_vreg_preg,
  input  logic [DATA_W-1:0]       vfpu_idu_ex5_pipe7_wb_vreg_data,
  input  logic                    lsu_idu_wb_pipe3_wb_vreg_vld,
  input  logic [PREG_W-1:0]       lsu_idu_wb_pipe3_wb_vreg_preg,
  input  logic [DATA_W-1:0]       lsu_idu_wb_pipe3_wb_vreg_data,
  input  logic [3:0]              dp_rf_vreg_alloc_vld,
  input  logic [4*PREG_W-1:0]     dp_rf_vreg_alloc_preg,
  output logic [3*PREG_NUM-1:0]   rf_vreg_x_wb_vld,
  output logic [DATA_W-1:0]       rf_vreg_pipe6_wb_data,
  output logic [DATA_W-1:0]       rf_vreg_pipe7_wb_data,
  output logic [DATA_W-1:0]       rf_vreg_pipe3_wb_data,
  output logic [PREG_NUM-1:0]     rf_vreg_ready,
  output logic                    rf_vreg_wb_collision_err
);

  // Handshake: each source asserts vld for exactly one cycle per write-back; there is no ready,
  // every valid beat is accepted and appears on the decode one cycle later. Index 0/1/2 = pipe6/pipe7/lsu.
  logic [2:0]        vld_d, vld_q;
  logic [PREG_W-1:0] preg_d [3];
  logic [PREG_W-1:0] preg_q [3];
  logic [DATA_W-1:0] data_d [3];
  logic [DATA_W-1:0] data_q [3];

  always_comb begin
    vld_d     = {lsu_idu_wb_pipe3_wb_vreg_vld, vfpu_idu_ex5_pipe7_wb_vreg_vld,
                 vfpu_idu_ex5_pipe6_wb_vreg_vld};
    preg_d[0] = vfpu_idu_ex5_pipe6_wb_vreg_preg;
    preg_d[1] = vfpu_idu_ex5_pipe7_wb_vreg_preg;
    preg_d[2] = lsu_idu_wb_pipe3_wb_vreg_preg;
    data_d[0] = vld_d[0] ? vfpu_idu_ex5_pipe6_wb_vreg_data : data_q[0];
    data_d[1] = vld_d[1] ? vfpu_idu_ex5_pipe7_wb_vreg_data : data_q[1];
    data_d[2] = vld_d[2] ? lsu_idu_wb_pipe3_wb_vreg_data   : data_q[2];
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld_q <= '0;
      for (int k = 0; k < 3; k++) begin
        preg_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < 3; k++) begin
        preg_q[k] <= preg_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  // Sources that survive collision masking; lsu outranks pipe7, which outranks pipe6.
  logic [2:0] keep;

  always_comb begin
    keep = vld_q;
`ifdef CT_IDU_VREG_WB_COLLISION_CHK_EN
    if (vld_q[2] && vld_q[1] && (preg_q[2] == preg_q[1]))
      keep[1] = 1'b0;
    if (vld_q[0] && ((vld_q[1] && (preg_q[1] == preg_q[0])) ||
                     (vld_q[2] && (preg_q[2] == preg_q[0]))))
      keep[0] = 1'b0;
`endif
  end

  logic [3*PREG_NUM-1:0] wb_vld;
  logic [PREG_NUM-1:0]   wb_set;
  logic [PREG_NUM-1:0]   alloc_hit;

  always_comb begin
    wb_vld    = '0;
    wb_set    = '0;
    alloc_hit = '0;
    for (int i = 0; i < PREG_NUM; i++) begin
      for (int k = 0; k < 3; k++)
        wb_vld[3*i+k] = keep[k] && (preg_q[k] == PREG_W'(i));
      wb_set[i] = |wb_vld[3*i +: 3];
      for (int s = 0; s < 4; s++)
        if (dp_rf_vreg_alloc_vld[s] && (dp_rf_vreg_alloc_preg[s*PREG_W +: PREG_W] == PREG_W'(i)))
          alloc_hit[i] = 1'b1;
    end
  end

  // Rename allocation wins over a same-cycle write-back: the new mapping is not yet produced.
  logic [PREG_NUM-1:0] ready_d, ready_q;

  always_comb begin
    ready_d = (ready_q | wb_set) & ~alloc_hit;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) ready_q <= '1;
    else           ready_q <= ready_d;
  end

`ifdef CT_IDU_VREG_WB_COLLISION_CHK_EN
  logic err_d, err_q;

  always_comb begin
    err_d = err_q | (|(vld_q & ~keep)) | (|(wb_set & alloc_hit));
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) err_q <= 1'b0;
    else           err_q <= err_d;
  end

  assign rf_vreg_wb_collision_err = err_q;
`else
  assign rf_vreg_wb_collision_err = 1'b0;
`endif

  assign rf_vreg_x_wb_vld      = wb_vld;
  assign rf_vreg_pipe6_wb_data = data_q[0];
  assign rf_vreg_pipe7_wb_data = data_q[1];
  assign rf_vreg_pipe3_wb_data = data_q[2];
  assign rf_vreg_ready         = ready_q;

endmodule

// File: tb/tb_ct_idu_rf_vreg_wb_stage.sv
// Bench for ct_idu_rf_vreg_wb_stage: directed scenarios plus random traffic checked by a set-based
// reference model; expected write-backs go through a queue consumed by an independent monitor.
module tb_ct_idu_rf_vreg_wb_stage;

  localparam int PN = 64;
  localparam int PW = 6;
  localparam int DW = 64;
`ifdef CT_IDU_VREG_WB_COLLISION_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [2:0]      in_vld;
  logic [PW-1:0]   in_preg [3];
  logic [DW-1:0]   in_data [3];
  logic [3:0]      in_avld;
  logic [PW-1:0]   in_apreg [4];

  logic [3*PN-1:0] x_wb_vld;
  logic [DW-1:0]   d6, d7, d3;
  logic [PN-1:0]   ready;
  logic            err;

  ct_idu_rf_vreg_wb_stage #(.PREG_NUM(PN), .PREG_W(PW), .DATA_W(DW)) dut (
    .forever_cpuclk                  (clk),
    .cpurst_b                        (rst_n),
    .vfpu_idu_ex5_pipe6_wb_vreg_vld  (in_vld[0]),
    .vfpu_idu_ex5_pipe6_wb_vreg_preg (in_preg[0]),
    .vfpu_idu_ex5_pipe6_wb_vreg_data (in_data[0]),
    .vfpu_idu_ex5_pipe7_wb_vreg_vld  (in_vld[1]),
    .vfpu_idu_ex5_pipe7_wb_vreg_preg (in_preg[1]),
    .vfpu_idu_ex5_pipe7_wb_vreg_data (in_data[1]),
    .lsu_idu_wb_pipe3_wb_vreg_vld    (in_vld[2]),
    .lsu_idu_wb_pipe3_wb_vreg_preg   (in_preg[2]),
    .lsu_idu_wb_pipe3_wb_vreg_data   (in_data[2]),
    .dp_rf_vreg_alloc_vld            (in_avld),
    .dp_rf_vreg_alloc_preg           ({in_apreg[3], in_apreg[2], in_apreg[1], in_apreg[0]}),
    .rf_vreg_x_wb_vld                (x_wb_vld),
    .rf_vreg_pipe6_wb_data           (d6),
    .rf_vreg_pipe7_wb_data           (d7),
    .rf_vreg_pipe3_wb_data           (d3),
    .rf_vreg_ready                   (ready),
    .rf_vreg_wb_collision_err        (err)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [3*PN-1:0] exp_q [$];
  logic [3*DW-1:0] exp_dat_q [$];

  // reference model: ready set, sticky error, held data, last cycle's accepted write-backs
  logic [PN-1:0] m_ready;
  logic          m_err;
  logic [DW-1:0] m_data [3];
  logic [2:0]    st_vld;
  logic [PW-1:0] st_preg [3];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = '1;
    m_err   = 1'b0;
    st_vld  = '0;
    for (int k = 0; k < 3; k++) begin
      m_data[k]  = '0;
      st_preg[k] = '0;
    end
    exp_q.delete();
    exp_dat_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    in_vld  = '0;
    in_avld = '0;
    for (int k = 0; k < 3; k++) begin
      in_preg[k] = PW'($urandom_range(0, PN-1));
      in_data[k] = {$urandom, $urandom};
    end
    for (int s = 0; s < 4; s++) in_apreg[s] = PW'($urandom_range(0, PN-1));
  endtask

  // Applies the current inputs for one clock, predicting what the DUT must show afterwards.
  task automatic drive_cycle();
    logic [PN-1:0]   wset, aset, n_ready;
    logic            n_err, keep_it;
    logic [3*PN-1:0] ev;
    logic [DW-1:0]   nd [3];
    wset = '0;
    aset = '0;
    n_err = m_err;
    for (int k = 0; k < 3; k++)
      if (st_vld[k]) wset[st_preg[k]] = 1'b1;
    for (int s = 0; s < 4; s++)
      if (in_avld[s]) aset[in_apreg[s]] = 1'b1;
    n_ready = (m_ready | wset) & ~aset;
    if (CHK) begin
      if ((wset & aset) != '0) n_err = 1'b1;
      for (int a = 0; a < 3; a++)
        for (int b = a + 1; b < 3; b++)
          if (st_vld[a] && st_vld[b] && st_preg[a] == st_preg[b]) n_err = 1'b1;
    end
    ev = '0;
    for (int k = 0; k < 3; k++) begin
      keep_it = in_vld[k];
      if (CHK)
        for (int h = k + 1; h < 3; h++)
          if (in_vld[h] && in_preg[h] == in_preg[k]) keep_it = 1'b0;
      if (keep_it) ev[3*int'(in_preg[k]) + k] = 1'b1;
      nd[k] = in_vld[k] ? in_data[k] : m_data[k];
    end
    if (ev != '0) begin
      exp_q.push_back(ev);
      exp_dat_q.push_back({nd[2], nd[1], nd[0]});
    end
    @(posedge clk);
    #1;
    m_ready = n_ready;
    m_err   = n_err;
    for (int k = 0; k < 3; k++) begin
      m_data[k]  = nd[k];
      st_preg[k] = in_preg[k];
    end
    st_vld = in_vld;
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      set_idle();
      drive_cycle();
    end
  endtask

  // Asserts reset between edges, checks the immediate reset values, then releases.
  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    #1;
    chk("rst_x_wb_vld", x_wb_vld, '0);
    chk("rst_ready", ready, {PN{1'b1}});
    chk("rst_err", err, 1'b0);
    chk("rst_data", {d3, d7, d6}, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (x_wb_vld != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wb", x_wb_vld, '0);
        end else begin
          chk("wb_vld", x_wb_vld, exp_q.pop_front());
          chk("wb_data", {d3, d7, d6}, exp_dat_q.pop_front());
        end
      end
      chk("ready", ready, m_ready);
      chk("err", err, m_err);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: idle after reset
    chk("t1_ready", ready, {PN{1'b1}});
    chk("t1_x_wb_vld", x_wb_vld, '0);
    chk("t1_err", err, 1'b0);
    idle_cycles(2);

    // 2: alloc preg 5, then pipe6 write-back to preg 5
    set_idle();
    in_avld = 4'b0001; in_apreg[0] = 6'd5;
    drive_cycle();
    chk("t2_ready5_c2", ready[5], 1'b0);
    idle_cycles(1);
    set_idle();
    in_vld[0] = 1'b1; in_preg[0] = 6'd5; in_data[0] = 64'h1122334455667788;
    drive_cycle();
    chk("t2_field5", x_wb_vld[17:15], 3'b001);
    chk("t2_data6", d6, 64'h1122334455667788);
    chk("t2_ready5_c4", ready[5], 1'b0);
    idle_cycles(1);
    chk("t2_ready5_c5", ready[5], 1'b1);

    // 3: three distinct pregs in one cycle
    set_idle();
    in_vld = 3'b111; in_preg[0] = 6'd10; in_preg[1] = 6'd11; in_preg[2] = 6'd12;
    drive_cycle();
    chk("t3_field10", x_wb_vld[32:30], 3'b001);
    chk("t3_field11", x_wb_vld[35:33], 3'b010);
    chk("t3_field12", x_wb_vld[38:36], 3'b100);
    idle_cycles(1);
    chk("t3_err", err, 1'b0);

    // 4: pipe7 and lsu collide on preg 20
    do_reset();
    set_idle();
    in_vld = 3'b110; in_preg[1] = 6'd20; in_preg[2] = 6'd20;
    drive_cycle();
    chk("t4_field20", x_wb_vld[62:60], CHK ? 3'b100 : 3'b110);
    idle_cycles(1);
    chk("t4_err", err, CHK);
    idle_cycles(10);
    chk("t4_err_sticky", err, CHK);

    // 5: staged write-back to preg 7 meets alloc slot2 preg 7
    do_reset();
    set_idle();
    in_vld[0] = 1'b1; in_preg[0] = 6'd7;
    drive_cycle();
    set_idle();
    in_avld = 4'b0100; in_apreg[2] = 6'd7;
    drive_cycle();
    chk("t5_ready7", ready[7], 1'b0);
    chk("t5_err", err, CHK);

    // 6: reset while a pipe6 write-back is staged
    idle_cycles(1);
    set_idle();
    in_vld[0] = 1'b1; in_preg[0] = 6'd9;
    drive_cycle();
    chk("t6_field9_pre", x_wb_vld[29:27], 3'b001);
    do_reset();
    idle_cycles(4);

    // random traffic with a narrow preg window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      if (n % 80 == 79) begin
        do_reset();
      end else begin
        set_idle();
        in_vld = 3'($urandom_range(0, 7));
        for (int k = 0; k < 3; k++)
          in_preg[k] = ($urandom_range(0, 1) == 0) ? PW'($urandom_range(0, 5))
                                                   : PW'($urandom_range(0, PN-1));
        if ($urandom_range(0, 2) == 0) in_avld = 4'($urandom_range(1, 15));
        for (int s = 0; s < 4; s++)
          in_apreg[s] = ($urandom_range(0, 1) == 0) ? PW'($urandom_range(0, 5))
                                                    : PW'($urandom_range(0, PN-1));
        drive_cycle();
      end
    end

    idle_cycles(3);
    chk("queue_drained", 192'(exp_q.size()), 192'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
